// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per two cycles.
// Unsigned or two's-complement operands, selected per operation.
module seq_shift_add_multiplier #(
  parameter int dp_width = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [dp_width-1:0]     Multiplicand,
  input  logic [dp_width-1:0]     Multiplier,
  output logic [2*dp_width-1:0]   Product,
  output logic                    ready,
  output logic                    done
);

  localparam int PW = $clog2(dp_width + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [dp_width-1:0] a_q, a_d;
  logic [dp_width-1:0] q_q, q_d;
  logic [dp_width-1:0] b_q, b_d;
  logic                c_q, c_d;
  logic [PW-1:0]       p_q, p_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;

  logic [dp_width:0]   sum_u;
  logic [dp_width:0]   sum_s;
  logic [dp_width:0]   dif_s;
  logic                last;

  assign sum_u = {1'b0, a_q} + {1'b0, b_q};
  assign sum_s = {a_q[dp_width-1], a_q} + {b_q[dp_width-1], b_q};
  assign dif_s = {a_q[dp_width-1], a_q} - {b_q[dp_width-1], b_q};
  assign last  = (p_q == PW'(1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    b_d     = b_q;
    c_d     = c_q;
    p_d     = p_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = '0;
          c_d     = 1'b0;
          q_d     = Multiplier;
          b_d     = Multiplicand;
          mode_d  = signed_mode;
          p_d     = PW'(dp_width);
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        p_d = p_q - PW'(1);
        if (q_q[0]) begin
          if (!mode_q) begin
            {c_d, a_d} = sum_u;
          end else if (last) begin
            // Sign bit of the multiplier carries weight -2^(n-1)
            {c_d, a_d} = dif_s;
          end else begin
            {c_d, a_d} = sum_s;
          end
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        c_d = mode_q ? c_q : 1'b0;
        a_d = {c_q, a_q[dp_width-1:1]};
        q_d = {a_q[0], q_q[dp_width-1:1]};
        if (p_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ADD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      c_q     <= c_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign Product = {a_q, q_q};
  assign ready   = (state_q == S_IDLE);
  assign done    = done_q;

endmodule
